mem_port_arbiter: RTL

//   Shares the single port of the unified 16K x 36 Von Neumann memory between the fetch unit (IF) and the load/store unit (LS).

---
 rtl/mem_port_arbiter.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single port of the unified 16K x 36 memory between the fetch
//   unit (IF) and the load/store unit (LS). LS has priority, but IF is
//   guaranteed a grant after MAX_LS_STREAK consecutive LS grants while it
//   waits. The memory command is registered (cycle T+1 after a transfer at
//   edge T). Read data is captured from i_mem_rdata at the edge that closes
//   the o_mem_re cycle and is presented, tagged to its requester, in T+2.
//   Optional feature macro: ARB_PERF_EN adds two saturating 16-bit
//   performance counters (IF stall cycles, LS transfers).
module mem_port_arbiter #(
    parameter int                    ADDR_WIDTH    = 14,
    parameter int                    DATA_WIDTH    = 36,
    parameter int                    INSTR_WIDTH   = 18,
    parameter logic [ADDR_WIDTH-1:0] MEM_BASE_ADDR = 14'h2000,
    parameter int                    MAX_LS_STREAK = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_if_req,
    input  logic [ADDR_WIDTH-1:0]  i_if_addr,
    output logic                   o_if_gnt,
    output logic                   o_if_rvalid,
    output logic [INSTR_WIDTH-1:0] o_if_instr,
    input  logic                   i_ls_req,
    input  logic                   i_ls_we,
    input  logic [ADDR_WIDTH-1:0]  i_ls_addr,
    input  logic [DATA_WIDTH-1:0]  i_ls_wdata,
    output logic                   o_ls_gnt,
    output logic                   o_ls_rvalid,
    output logic [DATA_WIDTH-1:0]  o_ls_rdata,
    output logic                   o_ls_fault,
    output logic [ADDR_WIDTH-1:0]  o_mem_addr,
    output logic                   o_mem_re,
    output logic                   o_mem_we,
    output logic [DATA_WIDTH-1:0]  o_mem_wdata,
    input  logic [DATA_WIDTH-1:0]  i_mem_rdata
`ifdef ARB_PERF_EN
    ,
    output logic [15:0]            o_perf_if_stall,
    output logic [15:0]            o_perf_ls_xfer
`endif
);

    localparam int STREAK_W = $clog2(MAX_LS_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_LS_STREAK);

    // Owner tag carried with each in-flight access.
    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_LS = 1'b1;

    logic                   ls_gnt;
    logic                   if_gnt;
    logic                   ls_xfer;
    logic                   if_xfer;
    logic                   ls_addr_bad;
    logic                   if_addr_ok;

    logic [STREAK_W-1:0]    streak_q,    streak_d;

    // Stage 1: memory command plus the tag of the access it belongs to.
    logic [ADDR_WIDTH-1:0]  mem_addr_q,  mem_addr_d;
    logic                   mem_re_q,    mem_re_d;
    logic                   mem_we_q,    mem_we_d;
    logic [DATA_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
    logic                   ls_fault_q,  ls_fault_d;
    logic                   tag1_valid_q, tag1_valid_d;
    logic                   tag1_owner_q, tag1_owner_d;
    logic                   tag1_nop_q,   tag1_nop_d;

    // Stage 2: registered responses.
    logic                   if_rvalid_q, if_rvalid_d;
    logic [INSTR_WIDTH-1:0] if_instr_q,  if_instr_d;
    logic                   ls_rvalid_q, ls_rvalid_d;
    logic [DATA_WIDTH-1:0]  ls_rdata_q,  ls_rdata_d;

    // Grant selection: LS wins unless IF has already waited out a full streak.
    // Grants are suppressed while reset is asserted so nothing is accepted.
    always_comb begin
        ls_addr_bad = (i_ls_addr >= MEM_BASE_ADDR);
        if_addr_ok  = (i_if_addr >= MEM_BASE_ADDR);
        ls_gnt      = i_rst_n && i_ls_req && !(i_if_req && (streak_q == STREAK_MAX));
        if_gnt      = i_rst_n && i_if_req && !ls_gnt;
        ls_xfer     = i_ls_req && ls_gnt;
        if_xfer     = i_if_req && if_gnt;
    end

    // Streak of LS grants taken while IF was waiting; saturating.
    always_comb begin
        streak_d = streak_q;
        if (if_xfer || !i_if_req) begin
            streak_d = '0;
        end else if (ls_xfer && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + 1'b1;
        end
    end

    // Stage 1: build the memory command and the response tag for a transfer.
    // Address/write data hold their last value when no access is issued.
    always_comb begin
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_re_d     = 1'b0;
        mem_we_d     = 1'b0;
        ls_fault_d   = 1'b0;
        tag1_valid_d = 1'b0;
        tag1_owner_d = OWNER_IF;
        tag1_nop_d   = 1'b0;
        if (ls_xfer) begin
            tag1_owner_d = OWNER_LS;
            if (ls_addr_bad) begin
                // Accepted but never reaches memory; no response either.
                ls_fault_d = 1'b1;
            end else if (i_ls_we) begin
                mem_we_d    = 1'b1;
                mem_addr_d  = i_ls_addr;
                mem_wdata_d = i_ls_wdata;
            end else begin
                mem_re_d     = 1'b1;
                mem_addr_d   = i_ls_addr;
                tag1_valid_d = 1'b1;
            end
        end else if (if_xfer) begin
            tag1_valid_d = 1'b1;
            tag1_owner_d = OWNER_IF;
            if (if_addr_ok) begin
                mem_re_d   = 1'b1;
                mem_addr_d = i_if_addr;
            end else begin
                // Out-of-region fetch returns a NOP without touching memory.
                tag1_nop_d = 1'b1;
            end
        end
    end

    // Stage 2: route returning data to its owner; the other side stays 0.
    always_comb begin
        if_rvalid_d = tag1_valid_q && (tag1_owner_q == OWNER_IF);
        ls_rvalid_d = tag1_valid_q && (tag1_owner_q == OWNER_LS);
        if_instr_d  = '0;
        ls_rdata_d  = '0;
        if (if_rvalid_d && !tag1_nop_q) begin
            if_instr_d = i_mem_rdata[INSTR_WIDTH-1:0];
        end
        if (ls_rvalid_d) begin
            ls_rdata_d = i_mem_rdata;
        end
    end

    // State and pipeline registers; reset flushes everything in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            streak_q     <= '0;
            mem_addr_q   <= '0;
            mem_re_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
            ls_fault_q   <= 1'b0;
            tag1_valid_q <= 1'b0;
            tag1_owner_q <= OWNER_IF;
            tag1_nop_q   <= 1'b0;
            if_rvalid_q  <= 1'b0;
            if_instr_q   <= '0;
            ls_rvalid_q  <= 1'b0;
            ls_rdata_q   <= '0;
        end else begin
            streak_q     <= streak_d;
            mem_addr_q   <= mem_addr_d;
            mem_re_q     <= mem_re_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
            ls_fault_q   <= ls_fault_d;
            tag1_valid_q <= tag1_valid_d;
            tag1_owner_q <= tag1_owner_d;
            tag1_nop_q   <= tag1_nop_d;
            if_rvalid_q  <= if_rvalid_d;
            if_instr_q   <= if_instr_d;
            ls_rvalid_q  <= ls_rvalid_d;
            ls_rdata_q   <= ls_rdata_d;
        end
    end

    assign o_if_gnt    = if_gnt;
    assign o_ls_gnt    = ls_gnt;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_re    = mem_re_q;
    assign o_mem_we    = mem_we_q;
    assign o_mem_wdata = mem_wdata_q;
    assign o_ls_fault  = ls_fault_q;
    assign o_if_rvalid = if_rvalid_q;
    assign o_if_instr  = if_instr_q;
    assign o_ls_rvalid = ls_rvalid_q;
    assign o_ls_rdata  = ls_rdata_q;

`ifdef ARB_PERF_EN
    logic [15:0] perf_if_stall_q, perf_if_stall_d;
    logic [15:0] perf_ls_xfer_q,  perf_ls_xfer_d;

    // Saturating counters: IF waiting cycles and accepted LS transfers.
    always_comb begin
        perf_if_stall_d = perf_if_stall_q;
        perf_ls_xfer_d  = perf_ls_xfer_q;
        if (i_if_req && !if_gnt && (perf_if_stall_q != 16'hFFFF)) begin
            perf_if_stall_d = perf_if_stall_q + 16'd1;
        end
        if (ls_xfer && (perf_ls_xfer_q != 16'hFFFF)) begin
            perf_ls_xfer_d = perf_ls_xfer_q + 16'd1;
        end
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            perf_if_stall_q <= '0;
            perf_ls_xfer_q  <= '0;
        end else begin
            perf_if_stall_q <= perf_if_stall_d;
            perf_ls_xfer_q  <= perf_ls_xfer_d;
        end
    end

    assign o_perf_if_stall = perf_if_stall_q;
    assign o_perf_ls_xfer  = perf_ls_xfer_q;
`endif

endmodule
